shift_reg_param: RTL and testbench
==================================

# shift_reg_param

Parametrised universal shift register with a command handshake. Replaces the fixed 8-bit two-mode shifter. Supports parallel load, clear, logical and arithmetic shifts, and rotates by a multi-bit amount, executed one bit per clock. Sits between a control FSM or CPU-style sequencer and any datapath that needs serialisation or bit alignment.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits (≥2).
- `AMT_W`, 4: width of the shift-amount field; max amount is 2^AMT_W−1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; equal to `~busy`.
- `op`  in  3  operation code, sampled on acceptance.
- `amount`  in  AMT_W  shift/rotate count, sampled on acceptance.
- `load_data`  in  WIDTH  parallel data for LOAD, sampled on acceptance.
- `ser_in`  in  1  serial fill bit; sampled live on every shift cycle.
- `out`  out  WIDTH  register contents.
- `ser_out`  out  1  bit about to leave: `out[WIDTH-1]` for left ops, `out[0]` otherwise (combinational from the registered op).
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Op codes: 000 NOP, 001 LOAD, 010 SHL (fill `ser_in`), 011 SHR (fill `ser_in`), 100 ROTL, 101 ROTR, 110 ASR (fill old MSB), 111 CLEAR.
- Command is accepted on an edge where `cmd_valid && cmd_ready`. Commands presented while busy are ignored, not queued.
- FSM states:
  - IDLE → SHIFT on accepting a shift or rotate op with `amount`≠0.
  - SHIFT → IDLE when the remaining count reaches 0.
- NOP, LOAD and CLEAR complete at the acceptance edge. LOAD sets `out`=`load_data`. CLEAR sets `out`=0. NOP leaves `out` unchanged.
- Shift or rotate with `amount`=0 completes at the acceptance edge with `out` unchanged.
- In SHIFT:
  - exactly one bit position moves per cycle;
  - the down-counter decrements each cycle;
  - `op` is held in an internal register.
- Amount greater than `WIDTH` is legal:
  - rotates wrap modulo `WIDTH` naturally;
  - SHL and SHR fill the whole register with the `ser_in` stream;
  - ASR saturates to all-MSB.
- Reset mid-operation aborts the command. No `done` pulse is produced.
- Reset values: `out`=0, `busy`=0, `done`=0, `cmd_ready`=1, internal count=0, state=IDLE.

## Timing
- Acceptance at edge k, shift op, amount N≥1:
  - `busy`=1 from edge k up to edge k+N;
  - `out` updates at edges k+1 … k+N;
  - `done`=1 for the single cycle after edge k+N;
  - `cmd_ready` returns to 1 after edge k+N.
- Single-cycle ops and amount 0: `out` updates at edge k, `done`=1 for the cycle after edge k, and `busy` stays 0.
- Back-to-back: a new command can be accepted in the same cycle that `done` is high. Throughput is one command per N+1 cycles.
- `ser_in` is sampled at each shifting edge (k+1 … k+N), not at acceptance.
- `done` is registered. `cmd_ready` and `ser_out` are combinational from registers only; there is no input-to-output combinational path.

## Structure
- Shared package `shift_reg_pkg` holds:
  - op-code constants (`OP_NOP` … `OP_CLEAR`);
  - FSM state encoding (`ST_IDLE`, `ST_SHIFT`).
- One sub-module, `shift_reg_step`: purely combinational, computes one-bit SHL/SHR/ROTL/ROTR/ASR of a `WIDTH` vector given `op` and `ser_in`.
- Top level holds the FSM, count register, op register, `out` register and the handshake.

## Test plan
All scenarios use WIDTH=8, AMT_W=4.
- Reset: hold `rst`=0 for 5 cycles → `out`=0x00, `busy`=0, `done`=0, `cmd_ready`=1. Drop `rst` low mid-ROTL → `out`=0x00 and `busy`=0 immediately, no `done` pulse.
- LOAD 0xA5, then ROTL amount 3 → `busy` high for 3 cycles, `out` sequence 0x4B, 0x96, 0x2D, single `done` pulse after the third shift.
- LOAD 0xA5, then SHR amount 4 with `ser_in`=1 → `out`=0xFA. LOAD 0x80, then ASR amount 3 → `out`=0xF0.
- LOAD 0xFF, then SHL amount 10 with `ser_in`=0 → `busy` high 10 cycles, final `out`=0x00, `ser_out` shows 1 for the first 8 shifts then 0.
- Edge handshakes:
  - ROTR amount 0 → `done` the next cycle, `out` unchanged, `busy` never high;
  - a LOAD 0x11 presented while busy → ignored, `out` unaffected;
  - a LOAD presented in the same cycle as `done` → accepted.
- CLEAR after LOAD 0x3C → `out`=0x00 in one cycle, `done` pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: op codes, FSM
// state encoding and a small op-classification helper.
package shift_reg_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROTL  = 3'b100;
  localparam logic [2:0] OP_ROTR  = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the multi-cycle ops (shifts and rotates).
  function automatic logic is_shift_op(input logic [2:0] op_v);
    logic res_v;
    case (op_v)
      OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR: res_v = 1'b1;
      default:                                  res_v = 1'b0;
    endcase
    return res_v;
  endfunction

  // True for ops whose outgoing bit is the MSB.
  function automatic logic is_left_op(input logic [2:0] op_v);
    logic res_v;
    case (op_v)
      OP_SHL, OP_ROTL: res_v = 1'b1;
      default:         res_v = 1'b0;
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// One-bit shift/rotate of a WIDTH vector. Purely combinational; ops that
// are not shifts or rotates pass the data through unchanged.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] result
);

  // Select the one-position move for the requested op.
  always_comb begin
    result = data;
    case (op)
      OP_SHL:  result = {data[WIDTH-2:0], ser_in};
      OP_SHR:  result = {ser_in, data[WIDTH-1:1]};
      OP_ROTL: result = {data[WIDTH-2:0], data[WIDTH-1]};
      OP_ROTR: result = {data[0], data[WIDTH-1:1]};
      OP_ASR:  result = {data[WIDTH-1], data[WIDTH-1:1]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_reg_param.sv
// Parametrised universal shift register with a valid/ready command port.
// Single-cycle ops (NOP, LOAD, CLEAR, zero-amount shifts) finish at the
// acceptance edge; shifts and rotates move one bit per clock while a
// down-counter runs out. done is a registered one-cycle pulse.
module shift_reg_param
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_e           state_r, state_nx_s;
  logic [AMT_W-1:0] cnt_r, cnt_nx_s;
  logic [2:0]       op_r, op_nx_s;
  logic [WIDTH-1:0] out_r, out_nx_s;
  logic             done_r, done_nx_s;
  logic [WIDTH-1:0] step_s;

  shift_reg_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data   (out_r),
    .op     (op_r),
    .ser_in (ser_in),
    .result (step_s)
  );

  // Next-state, counter, op-hold, data and completion logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    op_nx_s    = op_r;
    out_nx_s   = out_r;
    done_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_nx_s = op;
          if (is_shift_op(op) && (amount != CNT_ZERO)) begin
            state_nx_s = ST_SHIFT;
            cnt_nx_s   = amount;
          end else begin
            done_nx_s = 1'b1;
            case (op)
              OP_LOAD:  out_nx_s = load_data;
              OP_CLEAR: out_nx_s = {WIDTH{1'b0}};
              default:  out_nx_s = out_r;
            endcase
          end
        end else begin
          op_nx_s = op_r;
        end
      end
      ST_SHIFT: begin
        out_nx_s = step_s;
        cnt_nx_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // State registers; reset aborts any command in flight without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      op_r    <= OP_NOP;
      out_r   <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      op_r    <= op_nx_s;
      out_r   <= out_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign out       = out_r;
  assign done      = done_r;
  assign busy      = (state_r == ST_SHIFT);
  assign cmd_ready = ~busy;
  assign ser_out   = is_left_op(op_r) ? out_r[WIDTH-1] : out_r[0];

endmodule

// File: tb/tb_shift_reg_param.sv
// Directed self-checking bench for shift_reg_param (WIDTH=8, AMT_W=4).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_shift_reg_param;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] op;
  logic [3:0] amount;
  logic [7:0] load_data;
  logic       ser_in;
  logic [7:0] out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  localparam logic [2:0] C_NOP = 3'b000, C_LOAD = 3'b001, C_SHL = 3'b010,
                         C_SHR = 3'b011, C_ROTL = 3'b100, C_ROTR = 3'b101,
                         C_ASR = 3'b110, C_CLEAR = 3'b111;

  shift_reg_param #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op        (op),
    .amount    (amount),
    .load_data (load_data),
    .ser_in    (ser_in),
    .out       (out),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge; returns 1 ns after that edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    op        = o;
    amount    = a;
    load_data = d;
    tick();
    cmd_valid = 1'b0;
    op        = C_NOP;
    amount    = 4'd0;
    load_data = 8'h00;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    cmd_valid = 1'b0;
    op = C_NOP;
    amount = 4'd0;
    load_data = 8'h00;
    ser_in = 1'b0;

    // Reset held for five cycles.
    repeat (5) tick();
    check("rst_out", {24'd0, out}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b1;
    tick();

    // LOAD 0xA5 then ROTL 3 back-to-back in the done cycle.
    issue(C_LOAD, 4'd0, 8'hA5);
    check("load_out", {24'd0, out}, 32'hA5);
    check("load_done", {31'd0, done}, 32'd1);
    check("load_busy", {31'd0, busy}, 32'd0);
    issue(C_ROTL, 4'd3, 8'h00);
    check("rotl_busy0", {31'd0, busy}, 32'd1);
    check("rotl_ready0", {31'd0, cmd_ready}, 32'd0);
    check("rotl_out0", {24'd0, out}, 32'hA5);
    check("rotl_done0", {31'd0, done}, 32'd0);
    check("rotl_serout0", {31'd0, ser_out}, 32'd1);
    tick();
    check("rotl_out1", {24'd0, out}, 32'h4B);
    check("rotl_busy1", {31'd0, busy}, 32'd1);
    check("rotl_done1", {31'd0, done}, 32'd0);
    tick();
    check("rotl_out2", {24'd0, out}, 32'h96);
    check("rotl_busy2", {31'd0, busy}, 32'd1);
    check("rotl_done2", {31'd0, done}, 32'd0);
    tick();
    check("rotl_out3", {24'd0, out}, 32'h2D);
    check("rotl_busy3", {31'd0, busy}, 32'd0);
    check("rotl_done3", {31'd0, done}, 32'd1);
    check("rotl_ready3", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("rotl_done_end", {31'd0, done}, 32'd0);

    // LOAD 0xA5, SHR 4 with ser_in=1 -> 0xFA.
    issue(C_LOAD, 4'd0, 8'hA5);
    ser_in = 1'b1;
    issue(C_SHR, 4'd4, 8'h00);
    check("shr_serout0", {31'd0, ser_out}, 32'd1);
    repeat (4) tick();
    check("shr_out", {24'd0, out}, 32'hFA);
    check("shr_done", {31'd0, done}, 32'd1);
    ser_in = 1'b0;

    // LOAD 0x80, ASR 3 -> 0xF0.
    issue(C_LOAD, 4'd0, 8'h80);
    issue(C_ASR, 4'd3, 8'h00);
    repeat (3) tick();
    check("asr_out", {24'd0, out}, 32'hF0);
    check("asr_done", {31'd0, done}, 32'd1);

    // LOAD 0xFF, SHL 10 with ser_in=0: saturates to zero.
    issue(C_LOAD, 4'd0, 8'hFF);
    issue(C_SHL, 4'd10, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("shl_busy_%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("shl_serout_%0d", i), {31'd0, ser_out}, (i <= 8) ? 32'd1 : 32'd0);
      tick();
    end
    check("shl_out", {24'd0, out}, 32'h00);
    check("shl_busy_end", {31'd0, busy}, 32'd0);
    check("shl_done", {31'd0, done}, 32'd1);

    // ROTR amount 0: immediate completion, no busy.
    issue(C_LOAD, 4'd0, 8'h5A);
    issue(C_ROTR, 4'd0, 8'h00);
    check("rotr0_busy", {31'd0, busy}, 32'd0);
    check("rotr0_done", {31'd0, done}, 32'd1);
    check("rotr0_out", {24'd0, out}, 32'h5A);
    tick();
    check("rotr0_done_end", {31'd0, done}, 32'd0);

    // LOAD 0x11 while busy is ignored; LOAD 0xC3 in the done cycle is taken.
    issue(C_ROTL, 4'd2, 8'h00);
    issue(C_LOAD, 4'd0, 8'h11);
    check("ign_out1", {24'd0, out}, 32'hB4);
    check("ign_busy1", {31'd0, busy}, 32'd1);
    tick();
    check("ign_out2", {24'd0, out}, 32'h69);
    check("ign_done", {31'd0, done}, 32'd1);
    issue(C_LOAD, 4'd0, 8'hC3);
    check("b2b_out", {24'd0, out}, 32'hC3);
    check("b2b_done", {31'd0, done}, 32'd1);

    // NOP leaves the register alone but still pulses done.
    tick();
    issue(C_NOP, 4'd5, 8'hEE);
    check("nop_out", {24'd0, out}, 32'hC3);
    check("nop_done", {31'd0, done}, 32'd1);
    check("nop_busy", {31'd0, busy}, 32'd0);

    // CLEAR after LOAD 0x3C.
    issue(C_LOAD, 4'd0, 8'h3C);
    issue(C_CLEAR, 4'd0, 8'h00);
    check("clr_out", {24'd0, out}, 32'h00);
    check("clr_done", {31'd0, done}, 32'd1);

    // Reset mid-ROTL aborts without done.
    issue(C_LOAD, 4'd0, 8'hA5);
    issue(C_ROTL, 4'd5, 8'h00);
    tick();
    tick();
    check("abort_pre_out", {24'd0, out}, 32'h96);
    rst = 1'b0;
    #1;
    check("abort_out", {24'd0, out}, 32'h00);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort_nodone_%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("abort_idle_%0d", i), {31'd0, busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
